// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with dead-time blanking,
// frame-boundary value transfer and optional leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic        load_i,
    input  logic        lzs_i,
    output logic [3:0]  digit_o,
    output logic [3:0]  anode_o,
    output logic        ack_o
);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    localparam logic [15:0] BlankLast = 16'(BLANK_CYC - 1);
    localparam logic [15:0] DivLast   = 16'(DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] held_q, held_d;
    logic        pending_q, pending_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  digit_q, digit_d;
    logic [3:0]  anode_q, anode_d;
    logic        ack_q, ack_d;
    logic        frame_end;
    logic        suppress;

    assign frame_end = (state_q == StShow) && (cnt_q == DivLast) && (idx_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        idx_d     = idx_q;
        held_d    = held_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        ack_d     = 1'b0;

        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = 16'd0;
                end
            end
            StShow: begin
                if (cnt_q == DivLast) begin
                    state_d = StBlank;
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: ;
        endcase

        // Transfer uses the pre-edge held value; a coincident load re-arms pending.
        if (frame_end && pending_q) begin
            shadow_d  = held_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
        if (load_i) begin
            held_d    = value_i;
            pending_d = 1'b1;
        end

        // Outputs are derived from next-state so they are registered yet aligned to state.
        digit_d  = shadow_d[{idx_d, 2'b00} +: 4];
        suppress = lzs_i && (idx_d != 2'd0) && ((shadow_d >> {idx_d, 2'b00}) == 16'h0000);
        anode_d  = 4'b1111;
        if ((state_d == StShow) && !suppress) begin
            anode_d = ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StBlank;
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            held_q    <= 16'h0000;
            pending_q <= 1'b0;
            shadow_q  <= 16'h0000;
            digit_q   <= 4'h0;
            anode_q   <= 4'b1111;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            held_q    <= held_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            digit_q   <= digit_d;
            anode_q   <= anode_d;
            ack_q     <= ack_d;
        end
    end

    assign digit_o = digit_q;
    assign anode_o = anode_q;
    assign ack_o   = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (DIV=4/BLANK=2 and DIV=1/BLANK=1) on shared
// stimulus, each checked every cycle against a time-position model plus literal pins.
module tb_seg_scan_ctrl;

    localparam int S[2] = '{6, 2};
    localparam int B[2] = '{2, 1};

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        lzs;
    logic [3:0]  dig[2];
    logic [3:0]  an[2];
    logic        ak[2];

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset, transfer registers, sampled LZS.
    int          m_t[2];
    logic [15:0] m_held[2];
    logic [15:0] m_shadow[2];
    logic        m_pend[2];
    logic        m_ack[2];
    logic        m_lzs[2];
    logic        m_valid = 1'b0;

    seg_scan_ctrl #(.DIV(4), .BLANK_CYC(2)) u_dut_slow (
        .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load), .lzs_i(lzs),
        .digit_o(dig[0]), .anode_o(an[0]), .ack_o(ak[0])
    );

    seg_scan_ctrl #(.DIV(1), .BLANK_CYC(1)) u_dut_fast (
        .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load), .lzs_i(lzs),
        .digit_o(dig[1]), .anode_o(an[1]), .ack_o(ak[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic is_last(input int k, input int t);
        return (t % (4 * S[k])) == (4 * S[k] - 1);
    endfunction

    function automatic logic [3:0] exp_anode(input int k, input int t, input logic [15:0] sh,
                                             input logic lz);
        int p;
        int slot;
        logic [3:0] one;
        p    = t % (4 * S[k]);
        slot = p / S[k];
        one  = 4'b0001;
        if ((p % S[k]) < B[k]) return 4'b1111;
        if (lz && slot > 0 && (sh >> (4 * slot)) == 16'h0000) return 4'b1111;
        return ~(one << slot);
    endfunction

    function automatic logic [3:0] exp_digit(input int k, input int t, input logic [15:0] sh);
        int slot;
        slot = (t % (4 * S[k])) / S[k];
        return sh[4 * slot +: 4];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_lzs[k] <= lzs;
            if (rst) begin
                m_t[k]      <= 0;
                m_held[k]   <= 16'h0000;
                m_shadow[k] <= 16'h0000;
                m_pend[k]   <= 1'b0;
                m_ack[k]    <= 1'b0;
            end else begin
                m_t[k]   <= m_t[k] + 1;
                m_ack[k] <= is_last(k, m_t[k]) && m_pend[k];
                if (is_last(k, m_t[k]) && m_pend[k]) m_shadow[k] <= m_held[k];
                if (load) begin
                    m_held[k] <= value;
                    m_pend[k] <= 1'b1;
                end else if (is_last(k, m_t[k])) begin
                    m_pend[k] <= 1'b0;
                end
            end
        end
        if (rst) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %h want %h", name, m_t[0], act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk(k == 0 ? "slow anode" : "fast anode", 16'(an[k]),
                    16'(exp_anode(k, m_t[k], m_shadow[k], m_lzs[k])));
                chk(k == 0 ? "slow digit" : "fast digit", 16'(dig[k]),
                    16'(exp_digit(k, m_t[k], m_shadow[k])));
                chk(k == 0 ? "slow ack" : "fast ack", 16'(ak[k]), 16'(m_ack[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int g;
        g = 0;
        while (m_t[0] != target) begin
            tick();
            g++;
            if (g > 500) begin
                checks++;
                errors++;
                $display("FAIL run_to timeout: got t=%0d want t=%0d", m_t[0], target);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        value = 16'h0000;
        load  = 1'b0;
        lzs   = 1'b0;
        tick();
        tick();
        chk("reset anode", 16'(an[0]), 16'h000F);
        chk("reset digit", 16'(dig[0]), 16'h0000);
        chk("reset ack", 16'(ak[0]), 16'h0000);
        rst = 1'b0;

        // Idle scan pattern
        run_to(1);
        chk("idle slow t1", 16'(an[0]), 16'h000F);
        chk("idle fast t1", 16'(an[1]), 16'h000E);
        run_to(2);
        chk("idle slow t2", 16'(an[0]), 16'h000E);
        run_to(3);
        chk("idle fast t3", 16'(an[1]), 16'h000D);
        run_to(6);
        chk("idle slow t6", 16'(an[0]), 16'h000F);
        run_to(7);
        chk("idle fast t7", 16'(an[1]), 16'h0007);
        run_to(8);
        chk("idle slow t8", 16'(an[0]), 16'h000D);
        run_to(20);
        chk("idle slow t20", 16'(an[0]), 16'h0007);
        chk("idle digit", 16'(dig[0]), 16'h0000);

        // Mid-frame load appears at frame end
        run_to(30);
        do_load(16'h12AB);
        run_to(32);
        chk("fast ack 12AB", 16'(ak[1]), 16'h0001);
        run_to(33);
        chk("fast digit B", 16'(dig[1]), 16'h000B);
        run_to(47);
        chk("pre-transfer digit", 16'(dig[0]), 16'h0000);
        chk("pre-transfer ack", 16'(ak[0]), 16'h0000);
        run_to(48);
        chk("ack 12AB", 16'(ak[0]), 16'h0001);
        chk("digit B", 16'(dig[0]), 16'h000B);
        run_to(49);
        chk("ack one cycle", 16'(ak[0]), 16'h0000);
        run_to(54);
        chk("digit A", 16'(dig[0]), 16'h000A);
        run_to(60);
        chk("digit 2", 16'(dig[0]), 16'h0002);
        run_to(66);
        chk("digit 1", 16'(dig[0]), 16'h0001);

        // Leading-zero suppression
        run_to(70);
        lzs = 1'b1;
        do_load(16'h0050);
        run_to(74);
        chk("lzs d0 anode", 16'(an[0]), 16'h000E);
        chk("lzs d0 digit", 16'(dig[0]), 16'h0000);
        run_to(80);
        chk("lzs d1 anode", 16'(an[0]), 16'h000D);
        chk("lzs d1 digit", 16'(dig[0]), 16'h0005);
        run_to(86);
        chk("lzs d2 blank", 16'(an[0]), 16'h000F);
        run_to(92);
        chk("lzs d3 blank", 16'(an[0]), 16'h000F);
        run_to(94);
        lzs = 1'b0;
        run_to(110);
        chk("nolzs d2 anode", 16'(an[0]), 16'h000B);
        run_to(116);
        chk("nolzs d3 anode", 16'(an[0]), 16'h0007);

        // Multiple loads, last wins; load on frame-end edge carries over
        run_to(125);
        do_load(16'h1111);
        run_to(130);
        do_load(16'h2222);
        run_to(143);
        do_load(16'h3333);
        chk("ack 2222", 16'(ak[0]), 16'h0001);
        chk("digit 2222", 16'(dig[0]), 16'h0002);
        run_to(145);
        chk("single ack", 16'(ak[0]), 16'h0000);
        run_to(168);
        chk("ack 3333", 16'(ak[0]), 16'h0001);
        chk("digit 3333", 16'(dig[0]), 16'h0003);

        // Reset discards pending value just before frame end
        run_to(170);
        do_load(16'hFFFF);
        run_to(189);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst anode", 16'(an[0]), 16'h000F);
        chk("rst ack", 16'(ak[0]), 16'h0000);
        run_to(1);
        chk("post-rst blank", 16'(an[0]), 16'h000F);
        run_to(2);
        chk("post-rst lit", 16'(an[0]), 16'h000E);
        chk("post-rst digit", 16'(dig[0]), 16'h0000);
        run_to(24);
        chk("no ack after rst", 16'(ak[0]), 16'h0000);
        run_to(30);
        chk("shadow stays 0", 16'(dig[0]), 16'h0000);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL take parameter DIV, default 1000, giving the clock cycles each digit is lit per scan slot (legal range 1..65535).
REQ-002 The block SHALL take parameter BLANK_CYC, default 16, giving the all-off dead-time cycles before each lit slot (legal range 1..255).
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Value  input  16  four hex nibbles; Value[3:0] is digit 0 (rightmost).
REQ-006 Load  input  1  request to display Value; sampled every cycle.
REQ-007 LZS  input  1  leading-zero suppression enable; sampled every cycle.
REQ-008 Digit  output  4  nibble of the current slot, feeds the team's 7-segment decoder.
REQ-009 Anode  output  4  active-low digit enables; Anode[i] low lights digit i.
REQ-010 Ack  output  1  one-cycle pulse when a loaded value becomes visible.

Function
REQ-011 The block SHALL hold registers: Held[15:0], Pending, Shadow[15:0], Idx[1:0], State{BLANK,SHOW}, Cnt[15:0]; all outputs registered.
REQ-012 In BLANK, Anode SHALL be 4'b1111 and Cnt SHALL count 0..BLANK_CYC-1; on the edge at Cnt=BLANK_CYC-1, State SHALL become SHOW and Cnt 0.
REQ-013 In SHOW, Anode SHALL have only bit Idx low (unless suppressed per REQ-016); Cnt SHALL count 0..DIV-1; on the edge at Cnt=DIV-1, State SHALL become BLANK, Cnt 0, Idx=Idx+1 mod 4.
REQ-014 Each slot SHALL last exactly BLANK_CYC+DIV cycles; a frame SHALL last 4*(BLANK_CYC+DIV) cycles; no other transitions exist.
REQ-015 Digit SHALL equal Shadow[4*Idx+3:4*Idx] in both BLANK and SHOW, so the decoder output is settled before the anode turns on.
REQ-016 With LZS=1, digit i (i=1..3) SHALL be suppressed (Anode stays 4'b1111 through its SHOW phase) when Shadow nibbles i..3 are all zero; digit 0 is never suppressed.
REQ-017 Load=1 SHALL copy Value into Held and set Pending on that edge; several Loads before a transfer: last one wins, one Ack total.
REQ-018 The frame-end edge is the last SHOW cycle of Idx=3; on that edge, if Pending was set at the start of the cycle, Shadow SHALL take Held, Pending SHALL clear and Ack SHALL be 1 for the following cycle only.
REQ-019 Load coinciding with the frame-end edge: the transfer SHALL use the pre-edge Held; the new Value SHALL go to Held with Pending remaining set, transferring at the next frame end.
REQ-020 Shadow SHALL never change other than at a frame-end edge (no torn frames).

Reset
REQ-021 With Reset=1 at an edge, the block SHALL set State=BLANK, Cnt=0, Idx=0, Held=0, Shadow=0, Pending=0, Digit=4'h0, Anode=4'b1111, Ack=0, overriding Load.
REQ-022 Reset asserted mid-slot or with Pending set SHALL discard the pending value; scanning restarts at digit 0 BLANK the cycle after Reset deasserts.

Verification (DIV=4, BLANK_CYC=2 unless stated)
REQ-023 Reset, then idle 24 cycles -> Anode sequence per slot 1111,1111,1110x4 then 1111x2,1101x4, 1011, 0111 pattern; Digit=0 throughout; Ack=0.
REQ-024 Load=1 with Value=16'h12AB one cycle mid-frame -> Shadow unchanged until frame end; then Ack one cycle, Digit shows B,A,2,1 for Idx 0..3.
REQ-025 Value=16'h0050, LZS=1, loaded -> digits 2,3 Anode stay 1111 during SHOW; digit 1 lit with Digit=5; digit 0 lit with Digit=0; LZS=0 lights all four.
REQ-026 Load 16'h1111 then 16'h2222 before frame end, plus Load 16'h3333 on the frame-end cycle -> Shadow=2222 with one Ack; next frame Shadow=3333 with second Ack.
REQ-027 Load 16'hFFFF, then Reset two cycles before frame end -> Shadow stays 0, no Ack, Anode=1111 for BLANK_CYC cycles after release, then Anode=1110.
REQ-028 DIV=1, BLANK_CYC=1 -> slot period 2 cycles, frame 8 cycles, Anode alternates 1111 and one-low, transfer/Ack rules unchanged.
